// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/program-flow stage: FSM encoding,
// default widths and the absolute branch-target table.
package fetch_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_LUT_W = 5;
  localparam int DEF_CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Absolute BLTE/BGTE targets, indexed by the decoder's BrIdx field.
  localparam logic [DEF_PC_W-1:0] BR_TARGETS [0:(1<<DEF_LUT_W)-1] = '{
    1:       10'd12,
    3:       10'd40,
    default: 10'd0
  };

endpackage

// File: rtl/fetch_ctrl_br_lut.sv
// Combinational branch-target ROM: maps a table index to an absolute PC.
module br_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int LUT_W = DEF_LUT_W
) (
  input  logic [LUT_W-1:0] i_idx,
  output logic [PC_W-1:0]  o_target
);

  assign o_target = PC_W'(BR_TARGETS[i_idx]);

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and IDLE/RUN/DONE sequencing for the 8-bit core, with the
// Start/Done handshake toward the test harness.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int LUT_W = DEF_LUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             BrValid,
  input  logic             Jen,
  input  logic [LUT_W-1:0] BrIdx,
  input  logic             Stall,
  output logic [PC_W-1:0]  PC,
  output logic             Run,
  output logic             Done,
  output logic [CNT_W-1:0] CycCnt,
  output logic             Err,
  output logic [1:0]       o_dbg_state
);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [PC_W-1:0]  w_target;
  logic             w_pc_last;
  logic             w_cnt_max;

  br_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_br_lut (
    .i_idx    (BrIdx),
    .o_target (w_target)
  );

  assign w_pc_last = &r_pc;
  assign w_cnt_max = &r_cnt;

  // Handshake: Start is a single-cycle request honoured only in IDLE or DONE
  // (ignored in RUN); Run/Done follow one cycle later and Done holds until
  // the next accepted Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (Start) begin
            r_state <= RUN;
            r_pc    <= StartAddr;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        RUN: begin
          if (!w_cnt_max) r_cnt <= r_cnt + 1'b1;
          if (Stall) begin
            r_pc <= r_pc;
          end else if (Halt) begin
            r_state <= DONE;
          end else if (BrValid && Jen) begin
            r_pc <= w_target;
          end else if (w_pc_last) begin
            // Running off the top of memory ends the program rather than wrapping.
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign PC          = r_pc;
  assign Run         = (r_state == RUN);
  assign Done        = (r_state == DONE);
  assign CycCnt      = r_cnt;
  assign Err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural reference model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int PC_W  = 10;
  localparam int LUT_W = 5;
  localparam int CNT_W = 16;
  localparam int PC_MAX  = (1 << PC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset, Start, Halt, BrValid, Jen, Stall;
  logic [PC_W-1:0]  StartAddr;
  logic [LUT_W-1:0] BrIdx;
  logic [PC_W-1:0]  PC;
  logic             Run, Done, Err;
  logic [CNT_W-1:0] CycCnt;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Halt(Halt), .BrValid(BrValid), .Jen(Jen), .BrIdx(BrIdx), .Stall(Stall),
    .PC(PC), .Run(Run), .Done(Done), .CycCnt(CycCnt), .Err(Err),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 Clk = ~Clk;

  typedef struct {
    logic rst, st;
    int   addr;
    logic hl, bv, jn;
    int   idx;
    logic sl;
    int   pc;
    logic run, dn;
    int   cnt;
    logic er;
  } vec_t;

  function automatic vec_t mk(input logic rst, st, input int addr,
                              input logic hl, bv, jn, input int idx, input logic sl,
                              input int pc, input logic run, dn, input int cnt,
                              input logic er);
    vec_t r;
    r.rst = rst; r.st = st; r.addr = addr; r.hl = hl; r.bv = bv; r.jn = jn;
    r.idx = idx; r.sl = sl; r.pc = pc; r.run = run; r.dn = dn; r.cnt = cnt; r.er = er;
    return r;
  endfunction

  // driver tasks
  task automatic drive(input logic rst, st, input int addr, input logic hl, bv, jn,
                       input int idx, input logic sl);
    Reset = rst; Start = st; StartAddr = PC_W'(addr); Halt = hl;
    BrValid = bv; Jen = jn; BrIdx = LUT_W'(idx); Stall = sl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input logic run, dn,
                         input int cnt, input logic er);
    chk({tag, "_pc"},   int'(PC),     pc);
    chk({tag, "_run"},  int'(Run),    int'(run));
    chk({tag, "_done"}, int'(Done),   int'(dn));
    chk({tag, "_cnt"},  int'(CycCnt), cnt);
    chk({tag, "_err"},  int'(Err),    int'(er));
  endtask

  // reference model: program-level view (running / finished flags, plain ints)
  int tgt_tab [32];
  bit m_running, m_finished;
  int m_pc, m_cnt;
  bit m_err;

  task automatic model_step();
    if (Reset) begin
      m_running = 0; m_finished = 0; m_pc = 0; m_cnt = 0; m_err = 0;
    end else if (!m_running) begin
      if (Start) begin
        m_running = 1; m_finished = 0; m_pc = int'(StartAddr); m_cnt = 0; m_err = 0;
      end
    end else begin
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (Stall) begin
        // nothing else happens this cycle
      end else if (Halt) begin
        m_running = 0; m_finished = 1;
      end else if (BrValid && Jen) begin
        m_pc = tgt_tab[int'(BrIdx)];
      end else if (m_pc == PC_MAX) begin
        m_err = 1; m_running = 0; m_finished = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  vec_t tbl [21];
  // scoreboard for the randomized phase: expected PC values in arrival order
  logic [PC_W-1:0] exp_q [$];

  initial begin
    for (int i = 0; i < 32; i++) tgt_tab[i] = 0;
    tgt_tab[1] = 12;
    tgt_tab[3] = 40;

    //            rst st addr hl bv jn idx sl |  pc run dn cnt er
    tbl[0]  = mk(1, 0,   0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1,   5, 0, 0, 0, 0, 0,    5, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0,   0, 0, 0, 0, 0, 0,    6, 1, 0, 1, 0);
    tbl[3]  = mk(0, 0,   0, 0, 0, 0, 0, 0,    7, 1, 0, 2, 0);
    tbl[4]  = mk(0, 0,   0, 0, 0, 0, 0, 0,    8, 1, 0, 3, 0);
    tbl[5]  = mk(0, 0,   0, 0, 0, 0, 0, 0,    9, 1, 0, 4, 0);
    tbl[6]  = mk(0, 0,   0, 1, 0, 0, 0, 0,    9, 0, 1, 5, 0);
    tbl[7]  = mk(0, 0,   0, 0, 0, 0, 0, 0,    9, 0, 1, 5, 0);
    tbl[8]  = mk(0, 1,   6, 0, 0, 0, 0, 0,    6, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0,   0, 0, 0, 0, 0, 0,    7, 1, 0, 1, 0);
    tbl[10] = mk(0, 0,   0, 0, 1, 1, 3, 0,   40, 1, 0, 2, 0);
    tbl[11] = mk(0, 0,   0, 0, 1, 0, 3, 0,   41, 1, 0, 3, 0);
    tbl[12] = mk(0, 0,   0, 0, 0, 1, 3, 0,   42, 1, 0, 4, 0);
    tbl[13] = mk(0, 0,   0, 0, 1, 1, 1, 0,   12, 1, 0, 5, 0);
    tbl[14] = mk(0, 1, 100, 0, 0, 0, 0, 0,   13, 1, 0, 6, 0);
    tbl[15] = mk(0, 0,   0, 1, 0, 0, 0, 1,   13, 1, 0, 7, 0);
    tbl[16] = mk(0, 0,   0, 0, 1, 1, 3, 1,   13, 1, 0, 8, 0);
    tbl[17] = mk(0, 0,   0, 1, 1, 1, 3, 0,   13, 0, 1, 9, 0);
    tbl[18] = mk(0, 1,  12, 0, 0, 0, 0, 0,   12, 1, 0, 0, 0);
    tbl[19] = mk(0, 0,   0, 0, 1, 1, 2, 0,    0, 1, 0, 1, 0);
    tbl[20] = mk(0, 0,   0, 1, 0, 0, 0, 0,    0, 0, 1, 2, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("reset_state", int'(dbg_state), int'(IDLE));

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].addr, tbl[i].hl, tbl[i].bv, tbl[i].jn,
            tbl[i].idx, tbl[i].sl);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].run, tbl[i].dn, tbl[i].cnt, tbl[i].er);
    end

    // reset in the middle of a run
    drive(0, 1, 5, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
    chk_all("mid_run", 8, 1, 0, 3, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    chk_all("mid_reset", 0, 0, 0, 0, 0);
    chk("mid_reset_state", int'(dbg_state), int'(IDLE));
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk_all("idle_hold", 0, 0, 0, 0, 0);

    // end of memory
    drive(0, 1, 1022, 0, 0, 0, 0, 0); tick();
    chk_all("eom0", 1022, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk_all("eom1", 1023, 1, 0, 1, 0);
    tick();
    chk_all("eom_err", 1023, 0, 1, 2, 1);
    tick();
    chk_all("eom_hold", 1023, 0, 1, 2, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    chk_all("eom_restart", 0, 1, 0, 0, 0);

    // cycle counter saturation: stall keeps PC in place while RUN counts
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CNT_MAX + 1; i++) tick();
    chk_all("sat", 0, 1, 0, CNT_MAX, 0);
    tick();
    chk_all("sat_hold", 0, 1, 0, CNT_MAX, 0);

    // randomized traffic vs. reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_step(); tick();
    chk_all("rnd_rst", m_pc, m_running, m_finished, m_cnt, m_err);
    for (int i = 0; i < 3000; i++) begin
      int addr;
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, 1023);
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, addr,
            $urandom_range(0, 23) == 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 31),
            $urandom_range(0, 7) == 0);
      model_step();
      exp_q.push_back(PC_W'(m_pc));
      tick();
      chk("rnd_pc", int'(PC), int'(exp_q.pop_front()));
      chk("rnd_run", int'(Run), int'(m_running));
      chk("rnd_done", int'(Done), int'(m_finished));
      chk("rnd_cnt", int'(CycCnt), m_cnt);
      chk("rnd_err", int'(Err), int'(m_err));
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
